// File: rtl/ahb_master_pkg.sv
// ahb_master_pkg: AHB-Lite encodings, FSM state type and alignment helper shared by ahb_master.
// Also provides default `HDATA_BUS` / `HADDR_BUS` widths when the core defines have not set them.
// Encodings here are the ones the peripheral-bus slaves use.
`timescale 1ns/1ps
`ifndef HDATA_BUS
`define HDATA_BUS 32
`endif
`ifndef HADDR_BUS
`define HADDR_BUS 32
`endif

package ahb_master_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;

   localparam logic [2:0] HSIZE_BYTE    = 3'b000;
   localparam logic [2:0] HSIZE_HALF    = 3'b001;
   localparam logic [2:0] HSIZE_WORD    = 3'b010;

   localparam logic [1:0] HRESP_OKAY    = 2'b00;
   localparam logic [1:0] HRESP_ERROR   = 2'b01;

   // IDLE: no data phase outstanding; DATA: one data phase outstanding.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_DATA = 1'b1
   } state_e;

   // Sizes above a word are unsupported and are treated as misaligned.
   function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
      logic mis;
      mis = 1'b0;
      if (size > HSIZE_WORD) begin
         mis = 1'b1;
      end else if ((size == HSIZE_HALF) && addr_lo[0]) begin
         mis = 1'b1;
      end else if ((size == HSIZE_WORD) && (addr_lo != 2'b00)) begin
         mis = 1'b1;
      end
      return mis;
   endfunction

endpackage

// File: rtl/ahb_master.sv
// ahb_master: core req/gnt/rvalid interface to single AHB-Lite transfers (SINGLE burst, NONSEQ/IDLE only).
// Latency: grant at edge N (combinational gnt_o), data phase cycle N+1, rvalid_o in N+2; +1 per wait state, +1 for ERROR.
// Backpressure: gnt_o withheld while a data phase is stalled or during ERROR; misaligned requests get an error response.
// Ports: hclk/hreset (sync, active-high); core side req_i, we_i, size_i, addr_i, wdata_i -> gnt_o,
//   rvalid_o, rdata_o, err_o; AHB side haddr_o, hwrite_o, hsize_o, htrans_o, hburst_o, hwdata_o
//   <- hready_i, hresp_i, hrdata_i.
// Build option: define AHB_MST_PIPELINE_EN to overlap the next address phase with the completing data phase.
`timescale 1ns/1ps
`ifndef HDATA_BUS
`define HDATA_BUS 32
`endif
`ifndef HADDR_BUS
`define HADDR_BUS 32
`endif

module ahb_master
   import ahb_master_pkg::*;
(
   input  logic                   hclk,
   input  logic                   hreset,
   // core side
   input  logic                   req_i,
   input  logic                   we_i,
   input  logic [2:0]             size_i,
   input  logic [`HADDR_BUS-1:0]  addr_i,
   input  logic [`HDATA_BUS-1:0]  wdata_i,
   output logic                   gnt_o,
   output logic                   rvalid_o,
   output logic [`HDATA_BUS-1:0]  rdata_o,
   output logic                   err_o,
   // AHB side
   output logic [`HADDR_BUS-1:0]  haddr_o,
   output logic                   hwrite_o,
   output logic [2:0]             hsize_o,
   output logic [1:0]             htrans_o,
   output logic [2:0]             hburst_o,
   output logic [`HDATA_BUS-1:0]  hwdata_o,
   input  logic                   hready_i,
   input  logic [1:0]             hresp_i,
   input  logic [`HDATA_BUS-1:0]  hrdata_i
);

   state_e                  state_q, state_d;
   logic                    write_q, write_d;       // data-phase direction
   logic                    mis_pend_q, mis_pend_d; // misaligned error waiting behind a completion
   logic [`HDATA_BUS-1:0]   hwdata_q, hwdata_d;
   logic                    rvalid_q, rvalid_d;
   logic                    err_q, err_d;
   logic [`HDATA_BUS-1:0]   rdata_q, rdata_d;

   logic                    misaligned;
   logic                    permits;
   logic                    issue;
   logic                    mis_gnt;
   logic                    complete;

   assign misaligned = is_misaligned(size_i, addr_i[1:0]);

`ifdef AHB_MST_PIPELINE_EN
   // A queued misaligned error owns the next response slot, so hold off grants until it drains.
   assign permits = !hreset && !mis_pend_q && ((state_q == ST_IDLE) || hready_i);
`else
   assign permits = !hreset && (state_q == ST_IDLE);
`endif

   // The hresp_i term keeps the bus IDLE through both cycles of an ERROR response.
   assign issue    = req_i && !misaligned && hready_i && (hresp_i == HRESP_OKAY) && permits;
   assign mis_gnt  = req_i && misaligned && permits;
   assign complete = (state_q == ST_DATA) && hready_i;

   always_comb begin
      state_d    = state_q;
      write_d    = write_q;
      hwdata_d   = hwdata_q;
      mis_pend_d = mis_pend_q;
      rvalid_d   = 1'b0;
      err_d      = 1'b0;
      rdata_d    = '0;

      if (state_q == ST_IDLE) begin
         if (issue) begin
            state_d = ST_DATA;
         end
      end else begin
         if (complete) begin
            state_d = issue ? ST_DATA : ST_IDLE;
         end
      end

      if (issue) begin
         write_d  = we_i;
         hwdata_d = wdata_i;
      end

      // Response slot: a completing data phase is older than any misaligned request granted
      // in the same cycle, so that error is deferred by one cycle.
      if (complete) begin
         rvalid_d = 1'b1;
         if (hresp_i == HRESP_ERROR) begin
            err_d = 1'b1;
         end else if (!write_q) begin
            rdata_d = hrdata_i;
         end
         if (mis_gnt) begin
            mis_pend_d = 1'b1;
         end
      end else if (mis_pend_q) begin
         rvalid_d   = 1'b1;
         err_d      = 1'b1;
         mis_pend_d = 1'b0;
      end else if (mis_gnt) begin
         rvalid_d = 1'b1;
         err_d    = 1'b1;
      end
   end

   always_ff @(posedge hclk) begin
      if (hreset) begin
         state_q    <= ST_IDLE;
         write_q    <= 1'b0;
         mis_pend_q <= 1'b0;
         hwdata_q   <= '0;
         rvalid_q   <= 1'b0;
         err_q      <= 1'b0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         write_q    <= write_d;
         mis_pend_q <= mis_pend_d;
         hwdata_q   <= hwdata_d;
         rvalid_q   <= rvalid_d;
         err_q      <= err_d;
         rdata_q    <= rdata_d;
      end
   end

   assign gnt_o    = issue || mis_gnt;
   assign htrans_o = issue ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign haddr_o  = issue ? addr_i : '0;
   assign hwrite_o = issue ? we_i : 1'b0;
   assign hsize_o  = issue ? size_i : 3'b000;
   assign hburst_o = HBURST_SINGLE;
   assign hwdata_o = hwdata_q;
   assign rvalid_o = rvalid_q;
   assign err_o    = err_q;
   assign rdata_o  = rdata_q;

endmodule

// File: tb/tb_ahb_master.sv
// tb_ahb_master: directed vectors against ahb_master with a behavioural AHB slave and a response scoreboard.
// Expected responses (err, rdata, arrival cycle) are queued at grant; a monitor pops them on rvalid_o.
// Honours AHB_MST_PIPELINE_EN for the expected grant spacing.
`timescale 1ns/1ps
`ifndef HDATA_BUS
`define HDATA_BUS 32
`endif
`ifndef HADDR_BUS
`define HADDR_BUS 32
`endif

module tb_ahb_master;

`ifdef AHB_MST_PIPELINE_EN
   localparam int STEP = 1;
`else
   localparam int STEP = 2;
`endif

   logic                   hclk;
   logic                   hreset;
   logic                   req_i;
   logic                   we_i;
   logic [2:0]             size_i;
   logic [`HADDR_BUS-1:0]  addr_i;
   logic [`HDATA_BUS-1:0]  wdata_i;
   logic                   gnt_o;
   logic                   rvalid_o;
   logic [`HDATA_BUS-1:0]  rdata_o;
   logic                   err_o;
   logic [`HADDR_BUS-1:0]  haddr_o;
   logic                   hwrite_o;
   logic [2:0]             hsize_o;
   logic [1:0]             htrans_o;
   logic [2:0]             hburst_o;
   logic [`HDATA_BUS-1:0]  hwdata_o;
   logic                   hready_i;
   logic [1:0]             hresp_i;
   logic [`HDATA_BUS-1:0]  hrdata_i;

   ahb_master dut (
      .hclk     (hclk),
      .hreset   (hreset),
      .req_i    (req_i),
      .we_i     (we_i),
      .size_i   (size_i),
      .addr_i   (addr_i),
      .wdata_i  (wdata_i),
      .gnt_o    (gnt_o),
      .rvalid_o (rvalid_o),
      .rdata_o  (rdata_o),
      .err_o    (err_o),
      .haddr_o  (haddr_o),
      .hwrite_o (hwrite_o),
      .hsize_o  (hsize_o),
      .htrans_o (htrans_o),
      .hburst_o (hburst_o),
      .hwdata_o (hwdata_o),
      .hready_i (hready_i),
      .hresp_i  (hresp_i),
      .hrdata_i (hrdata_i)
   );

   typedef struct {
      string       name;
      logic        err;
      logic [31:0] rdata;
      int          cyc;
   } exp_t;

   typedef struct {
      int   waits;
      logic err;
   } cfg_t;

   exp_t exp_q[$];
   cfg_t cfg_q[$];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   initial begin
      hclk = 1'b0;
      forever #5 hclk = ~hclk;
   end

   always @(posedge hclk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Slave read data: fixed word at 0x100, otherwise a pattern derived from the address.
   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
      return a ^ 32'hA5A5_0000;
   endfunction

   // Behavioural AHB slave: samples the bus mid-cycle, updates just after the edge.
   initial begin
      logic        cap_ns, cap_rdy, cap_rst;
      logic [31:0] cap_addr;
      logic        dp_act, dp_err, err_ph;
      int          wleft;
      logic [31:0] dp_rd;
      cfg_t        c;
      hready_i = 1'b1;
      hresp_i  = 2'b00;
      hrdata_i = '0;
      dp_act   = 1'b0;
      dp_err   = 1'b0;
      err_ph   = 1'b0;
      wleft    = 0;
      dp_rd    = '0;
      forever begin
         @(negedge hclk);
         cap_ns   = (htrans_o == 2'b10);
         cap_rdy  = hready_i;
         cap_rst  = hreset;
         cap_addr = haddr_o;
         @(posedge hclk);
         #1;
         if (cap_rst) begin
            dp_act = 1'b0;
         end else begin
            if (dp_act) begin
               if (cap_rdy) dp_act = 1'b0;
               else if (wleft > 0) wleft--;
               else err_ph = 1'b1;
            end
            if (cap_ns && cap_rdy) begin
               if (cfg_q.size() > 0) c = cfg_q.pop_front();
               else c = '{waits: 0, err: 1'b0};
               dp_act = 1'b1;
               wleft  = c.waits;
               dp_err = c.err;
               err_ph = 1'b0;
               dp_rd  = mem_rd(cap_addr);
            end
         end
         hrdata_i = '0;
         if (!dp_act) begin
            hready_i = 1'b1;
            hresp_i  = 2'b00;
         end else if (wleft > 0) begin
            hready_i = 1'b0;
            hresp_i  = 2'b00;
         end else if (dp_err) begin
            hready_i = err_ph;
            hresp_i  = 2'b01;
            hrdata_i = dp_rd;
         end else begin
            hready_i = 1'b1;
            hresp_i  = 2'b00;
            hrdata_i = dp_rd;
         end
      end
   end

   // Response monitor.
   initial begin
      exp_t e;
      forever begin
         @(negedge hclk);
         if (rvalid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("unexpected rvalid", 64'(1), 64'(0));
            end else begin
               e = exp_q.pop_front();
               check({e.name, " rsp err"},   64'(err_o),   64'(e.err));
               check({e.name, " rsp rdata"}, 64'(rdata_o), 64'(e.rdata));
               check({e.name, " rsp cycle"}, 64'(cyc),     64'(e.cyc));
            end
         end
      end
   end

   // Drive one request (left asserted on return, one cycle after its grant).
   task automatic do_req(input string name, input logic we, input logic [2:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata, input int waits,
                         input logic serr, input logic exp_mis, input logic exp_err,
                         input logic [31:0] exp_rdata, output int gcyc);
      logic granted;
      int   lat;
      req_i   = 1'b1;
      we_i    = we;
      size_i  = size;
      addr_i  = addr;
      wdata_i = wdata;
      granted = 1'b0;
      gcyc    = -1;
      for (int k = 0; k < 20 && !granted; k++) begin
         @(negedge hclk);
         if (gnt_o === 1'b1) begin
            granted = 1'b1;
            gcyc    = cyc;
            check({name, " htrans"}, 64'(htrans_o), exp_mis ? 64'(2'b00) : 64'(2'b10));
            if (!exp_mis) begin
               check({name, " haddr"},  64'(haddr_o),  64'(addr));
               check({name, " hsize"},  64'(hsize_o),  64'(size));
               check({name, " hwrite"}, 64'(hwrite_o), 64'(we));
               check({name, " hburst"}, 64'(hburst_o), 64'(3'b000));
               cfg_q.push_back('{waits: waits, err: serr});
               lat = 2 + waits + (serr ? 1 : 0);
            end else begin
               lat = 1;
            end
            exp_q.push_back('{name: name, err: exp_err, rdata: exp_rdata, cyc: cyc + lat});
         end else begin
            check({name, " idle while waiting"}, 64'(htrans_o), 64'(2'b00));
         end
         @(posedge hclk);
         #1;
      end
      if (!granted) check({name, " grant timeout"}, 64'(0), 64'(1));
   endtask

   task automatic idle(input int n);
      req_i = 1'b0;
      repeat (n) begin
         @(posedge hclk);
         #1;
      end
   endtask

   task automatic check_reset_vals(input string name);
      check({name, " gnt"},    64'(gnt_o),    64'(0));
      check({name, " rvalid"}, 64'(rvalid_o), 64'(0));
      check({name, " err"},    64'(err_o),    64'(0));
      check({name, " rdata"},  64'(rdata_o),  64'(0));
      check({name, " hwdata"}, 64'(hwdata_o), 64'(0));
      check({name, " htrans"}, 64'(htrans_o), 64'(0));
      check({name, " hburst"}, 64'(hburst_o), 64'(0));
      check({name, " haddr"},  64'(haddr_o),  64'(0));
   endtask

   initial begin
      int g0, g1, g2, g3;
      hreset  = 1'b1;
      req_i   = 1'b1;   // held during reset: must not be granted
      we_i    = 1'b0;
      size_i  = 3'b010;
      addr_i  = 32'h0000_0100;
      wdata_i = 32'hFFFF_FFFF;
      @(posedge hclk);
      @(negedge hclk);
      check_reset_vals("reset");
      @(posedge hclk);
      #1;
      hreset = 1'b0;
      req_i  = 1'b0;
      idle(1);

      // Zero-wait word read.
      do_req("rd 0x100", 1'b0, 3'b010, 32'h0000_0100, 32'h0, 0, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, g0);
      idle(4);

      // Byte write with two wait states; write data held through the data phase.
      do_req("wr 0x8003", 1'b1, 3'b000, 32'h0000_8003, 32'h0000_00A5, 2, 1'b0, 1'b0, 1'b0, 32'h0, g0);
      req_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge hclk);
         check("wr 0x8003 hwdata hold", 64'(hwdata_o), 64'(32'h0000_00A5));
      end
      idle(4);

      // Four word reads requested back to back.
      do_req("rd 0x200", 1'b0, 3'b010, 32'h0000_0200, 32'h0, 0, 1'b0, 1'b0, 1'b0, 32'hA5A5_0200, g0);
      do_req("rd 0x204", 1'b0, 3'b010, 32'h0000_0204, 32'h0, 0, 1'b0, 1'b0, 1'b0, 32'hA5A5_0204, g1);
      do_req("rd 0x208", 1'b0, 3'b010, 32'h0000_0208, 32'h0, 0, 1'b0, 1'b0, 1'b0, 32'hA5A5_0208, g2);
      do_req("rd 0x20C", 1'b0, 3'b010, 32'h0000_020C, 32'h0, 0, 1'b0, 1'b0, 1'b0, 32'hA5A5_020C, g3);
      idle(4);
      check("b2b grant spacing 1", 64'(g1 - g0), 64'(STEP));
      check("b2b grant spacing 2", 64'(g2 - g1), 64'(STEP));
      check("b2b grant spacing 3", 64'(g3 - g2), 64'(STEP));

      // Two-cycle ERROR on a write with the next read already requested.
      do_req("wr 0x300 err", 1'b1, 3'b010, 32'h0000_0300, 32'h1111_2222, 0, 1'b1, 1'b0, 1'b1, 32'h0, g0);
      do_req("rd 0x304", 1'b0, 3'b010, 32'h0000_0304, 32'h0, 0, 1'b0, 1'b0, 1'b0, 32'hA5A5_0304, g1);
      idle(4);
      check("grant after ERROR", 64'(g1 - g0), 64'(3));

      // Misalignment rules and an aligned halfword boundary case.
      do_req("mis word 0x102", 1'b0, 3'b010, 32'h0000_0102, 32'h0, 0, 1'b0, 1'b1, 1'b1, 32'h0, g0);
      idle(2);
      do_req("mis half 0x101", 1'b1, 3'b001, 32'h0000_0101, 32'h0, 0, 1'b0, 1'b1, 1'b1, 32'h0, g0);
      idle(2);
      do_req("mis size 011", 1'b0, 3'b011, 32'h0000_0000, 32'h0, 0, 1'b0, 1'b1, 1'b1, 32'h0, g0);
      idle(2);
      do_req("half 0x102", 1'b0, 3'b001, 32'h0000_0102, 32'h0, 0, 1'b0, 1'b0, 1'b0, 32'hA5A5_0102, g0);
      idle(4);

      // Reset during a wait-stated read: response is abandoned.
      do_req("rd 0x400 rst", 1'b0, 3'b010, 32'h0000_0400, 32'h1234_5678, 5, 1'b0, 1'b0, 1'b0, 32'hA5A5_0400, g0);
      idle(1);
      hreset = 1'b1;
      exp_q.delete();
      cfg_q.delete();
      @(posedge hclk);
      @(negedge hclk);
      check_reset_vals("mid-transfer reset");
      @(posedge hclk);
      #1;
      hreset = 1'b0;
      idle(10);

      // Recovery after reset.
      do_req("rd 0x100 post-rst", 1'b0, 3'b010, 32'h0000_0100, 32'h0, 0, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, g0);
      idle(2);

      for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge hclk);
      @(negedge hclk);
      check("responses outstanding at end", 64'(exp_q.size()), 64'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
